// File: rtl/vga_sync_640_480_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, derived totals and sync
// windows, plus small helpers reused by other display modes.
package vga_sync_640_480_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL    = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL    = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int unsigned VGA_HS_START   = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_HS_END     = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START   = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_VS_END     = VGA_VS_START + VGA_V_SYNC;

  localparam int unsigned CNT_W = 10;

  function automatic int unsigned mode_total(int unsigned vis, int unsigned fp,
                                             int unsigned sw, int unsigned bp);
    return vis + fp + sw + bp;
  endfunction

  // Half-open window test [lo, hi) on a counter value.
  function automatic logic in_window(logic [CNT_W-1:0] c, logic [CNT_W-1:0] lo,
                                     logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_sync_640_480_if.sv
// Timing-source bundle: strobe/clear in, sync levels, enables and indices out.
interface vga_sync_640_480_if;
  logic       i_sclr;
  logic       i_px_clk;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_haddr_en;
  logic       o_vaddr_en;
  logic [9:0] o_hidx;
  logic [8:0] o_vidx;
  logic       o_frame_start;

  modport master (
    output i_sclr, i_px_clk,
    input  o_hsync, o_vsync, o_haddr_en, o_vaddr_en, o_hidx, o_vidx, o_frame_start
  );

  modport slave (
    input  i_sclr, i_px_clk,
    output o_hsync, o_vsync, o_haddr_en, o_vaddr_en, o_hidx, o_vidx, o_frame_start
  );
endinterface

// File: rtl/vga_sync_640_480_counter.sv
// Modulo-N counter with enable and synchronous clear; wrap flags the enabled
// cycle on which the count rolls over from N-1 to 0.
module vga_sync_640_480_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sclr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_640_480.sv
// VGA timing source: strobe-driven h/v counters decoded into sync levels,
// visible-area enables/indices and a frame-start pulse.
module vga_sync_640_480
  import vga_sync_640_480_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  vga_sync_640_480_if.slave    vga
);

  localparam int unsigned H_TOTAL = mode_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = mode_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_en;
  logic             frame_start_p1;

  assign v_en = vga.i_px_clk & h_wrap;

  vga_sync_640_480_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .sclr  (vga.i_sclr),
    .en    (vga.i_px_clk),
    .cnt   (hcnt),
    .wrap  (h_wrap)
  );

  vga_sync_640_480_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .sclr  (vga.i_sclr),
    .en    (v_en),
    .cnt   (vcnt),
    .wrap  (v_wrap)
  );

  // v_wrap already implies a strobe on the last pixel of the last line.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= v_wrap & ~vga.i_sclr;
    end
  end

  // Zero-latency decode of the registered counters.
  always_comb begin
    vga.o_haddr_en    = (hcnt < H_VIS_C);
    vga.o_vaddr_en    = (vcnt < V_VIS_C);
    vga.o_hidx        = vga.o_haddr_en ? hcnt : '0;
    vga.o_vidx        = vga.o_vaddr_en ? vcnt[8:0] : '0;
    vga.o_hsync       = ~in_window(hcnt, HS_LO, HS_HI);
    vga.o_vsync       = ~in_window(vcnt, VS_LO, VS_HI);
    vga.o_frame_start = frame_start_p1;
  end

endmodule
